// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA timing generator with pixel-enable divider, line/frame strobes and an optional VGA_TIMING_PIPE_EN sync/blank delay line
module vga_timing_gen #(
  parameter int H_RES = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_RES = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter logic H_POL = 1'b0,
  parameter logic V_POL = 1'b0,
  parameter int PIX_DIV = 4,
  parameter int CNT_W = 12,
  parameter int PIPE_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  input logic en,
  output logic pix_tick,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic hsync,
  output logic vsync,
  output logic video_on,
  output logic line_start,
  output logic frame_start
);
  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_RES);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_RES);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_RES + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_RES + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_RES + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_RES + V_FP + V_SYNC);
  if (PIX_DIV < 1 || PIPE_DEPTH < 1 || H_TOTAL > 2 ** CNT_W || V_TOTAL > 2 ** CNT_W) begin : g_bad_cfg
    $error("vga_timing_gen: invalid parameters");
  end
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic tick_q, tick_d, hs_q, hs_d, vs_q, vs_d, vo_q, vo_d, ls_q, ls_d, fs_q, fs_d;
  logic adv;
  always_comb begin
    adv = en && tick_q;
    div_d = en ? (div_q == DIV_LAST ? '0 : div_q + 1'b1) : div_q;
    tick_d = en ? div_q == DIV_LAST : tick_q;
    h_d = adv ? (h_q == H_LAST ? '0 : h_q + 1'b1) : h_q;
    v_d = adv && h_q == H_LAST ? (v_q == V_LAST ? '0 : v_q + 1'b1) : v_q;
    ls_d = en ? adv && h_q == H_LAST : ls_q;
    fs_d = en ? adv && h_q == H_LAST && v_q == V_LAST : fs_q;
    hs_d = en ? (h_d >= HS_BEG && h_d < HS_END ? H_POL : ~H_POL) : hs_q;
    vs_d = en ? (v_d >= VS_BEG && v_d < VS_END ? V_POL : ~V_POL) : vs_q;
    vo_d = en ? h_d < H_ACT && v_d < V_ACT : vo_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      tick_q <= 1'b0;
      h_q <= '0;
      v_q <= '0;
      hs_q <= ~H_POL;
      vs_q <= ~V_POL;
      vo_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tick_q <= tick_d;
      h_q <= h_d;
      v_q <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      vo_q <= vo_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end
  assign pix_tick = tick_q & en;
  assign line_start = ls_q & en;
  assign frame_start = fs_q & en;
  assign h_count = h_q;
  assign v_count = v_q;
`ifdef VGA_TIMING_PIPE_EN
  logic [PIPE_DEPTH-1:0] hs_p_q, hs_p_d, vs_p_q, vs_p_d, vo_p_q, vo_p_d;
  always_comb begin
    hs_p_d = adv ? PIPE_DEPTH'({hs_p_q, hs_q}) : hs_p_q;
    vs_p_d = adv ? PIPE_DEPTH'({vs_p_q, vs_q}) : vs_p_q;
    vo_p_d = adv ? PIPE_DEPTH'({vo_p_q, vo_q}) : vo_p_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p_q <= {PIPE_DEPTH{~H_POL}};
      vs_p_q <= {PIPE_DEPTH{~V_POL}};
      vo_p_q <= '0;
    end else begin
      hs_p_q <= hs_p_d;
      vs_p_q <= vs_p_d;
      vo_p_q <= vo_p_d;
    end
  end
  assign hsync = hs_p_q[PIPE_DEPTH-1];
  assign vsync = vs_p_q[PIPE_DEPTH-1];
  assign video_on = vo_p_q[PIPE_DEPTH-1];
`else
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign video_on = vo_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen against an arithmetic frame-position model
module tb_vga_timing_gen;
  localparam int PD = 2;
  localparam int SHR = 16, SHF = 4, SHS = 6, SHB = 5, SVR = 8, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHR + SHF + SHS + SHB;
  localparam int SVT = SVR + SVF + SVS + SVB;
  typedef struct packed {
    logic tick;
    logic [11:0] h;
    logic [11:0] v;
    logic hs;
    logic vs;
    logic vo;
    logic ls;
    logic fs;
  } obs_t;
  typedef struct {
    int p, hr, hf, hs, hb, vr, vf, vs, vb;
    bit hp, vp;
  } cfg_t;
  typedef struct {
    int h, v;
    bit tick, hs, vs, vo, ls, fs;
  } exp_t;
  typedef struct {
    bit en;
    int cyc;
    int h, v;
    bit tick, ls, fs;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  obs_t o0, o1, o2;
  cfg_t cfgs[3];
  vec_t tbl[6];
  string names[3] = '{"dflt", "small", "pol"};
  int k;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else if (en) k <= k + 1;
  end
  vga_timing_gen #(.PIPE_DEPTH(PD)) u_d (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(o0.tick), .h_count(o0.h), .v_count(o0.v),
    .hsync(o0.hs), .vsync(o0.vs), .video_on(o0.vo), .line_start(o0.ls), .frame_start(o0.fs)
  );
  vga_timing_gen #(
    .H_RES(SHR), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB), .V_RES(SVR), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .H_POL(1'b0), .V_POL(1'b0), .PIX_DIV(3), .CNT_W(12), .PIPE_DEPTH(PD)
  ) u_s (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(o1.tick), .h_count(o1.h), .v_count(o1.v),
    .hsync(o1.hs), .vsync(o1.vs), .video_on(o1.vo), .line_start(o1.ls), .frame_start(o1.fs)
  );
  vga_timing_gen #(
    .H_RES(SHR), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB), .V_RES(SVR), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(1), .CNT_W(12), .PIPE_DEPTH(PD)
  ) u_p (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(o2.tick), .h_count(o2.h), .v_count(o2.v),
    .hsync(o2.hs), .vsync(o2.vs), .video_on(o2.vo), .line_start(o2.ls), .frame_start(o2.fs)
  );
  // Expected outputs after kk enabled clock edges since reset; e is the current en level
  function automatic exp_t model(cfg_t c, int kk, bit e);
    exp_t r;
    int ht, vt, n, m, mh, mv;
    bit adv;
    ht = c.hr + c.hf + c.hs + c.hb;
    vt = c.vr + c.vf + c.vs + c.vb;
    n = kk > 0 ? (kk - 1) / c.p : 0;
    r.h = n % ht;
    r.v = (n / ht) % vt;
    r.tick = e && kk > 0 && kk % c.p == 0;
    adv = kk > c.p && (kk - 1) % c.p == 0;
    r.ls = e && adv && r.h == 0;
    r.fs = r.ls && r.v == 0;
`ifdef VGA_TIMING_PIPE_EN
    m = n - PD;
`else
    m = n;
`endif
    if (kk == 0 || m < 0) begin
      r.hs = !c.hp;
      r.vs = !c.vp;
      r.vo = 1'b0;
    end else begin
      mh = m % ht;
      mv = (m / ht) % vt;
      r.hs = (mh >= c.hr + c.hf && mh < c.hr + c.hf + c.hs) ? c.hp : !c.hp;
      r.vs = (mv >= c.vr + c.vf && mv < c.vr + c.vf + c.vs) ? c.vp : !c.vp;
      r.vo = mh < c.hr && mv < c.vr;
    end
    return r;
  endfunction
  function automatic obs_t pick(int i);
    return i == 0 ? o0 : (i == 1 ? o1 : o2);
  endfunction
  task automatic cmp(int i, string f, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s k=%0d got %0d want %0d", names[i], f, k, act, exp);
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      obs_t o;
      exp_t e;
      o = pick(i);
      e = model(cfgs[i], k, en);
      cmp(i, "pix_tick", int'(o.tick), int'(e.tick));
      cmp(i, "h_count", int'(o.h), e.h);
      cmp(i, "v_count", int'(o.v), e.v);
      cmp(i, "hsync", int'(o.hs), int'(e.hs));
      cmp(i, "vsync", int'(o.vs), int'(e.vs));
      cmp(i, "video_on", int'(o.vo), int'(e.vo));
      cmp(i, "line_start", int'(o.ls), int'(e.ls));
      cmp(i, "frame_start", int'(o.fs), int'(e.fs));
    end
  endtask
  initial begin
    int nfs, ticks;
    cfgs[0] = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfgs[1] = '{3, SHR, SHF, SHS, SHB, SVR, SVF, SVS, SVB, 1'b0, 1'b0};
    cfgs[2] = '{1, SHR, SHF, SHS, SHB, SVR, SVF, SVS, SVB, 1'b1, 1'b1};
    tbl[0] = '{1'b1, 4, 1, 0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 37, 1, 0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 3, 2, 0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 90, 1, 1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1299, 0, 0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 2, 0, 0, 1'b1, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(negedge clk);
    check_all();
    for (int s = 0; s < 6; s++) begin
      en = tbl[s].en;
      repeat (tbl[s].cyc) begin
        @(negedge clk);
        check_all();
      end
      cmp(1, "tbl_h", int'(o1.h), tbl[s].h);
      cmp(1, "tbl_v", int'(o1.v), tbl[s].v);
      cmp(1, "tbl_tick", int'(o1.tick), int'(tbl[s].tick));
      cmp(1, "tbl_line_start", int'(o1.ls), int'(tbl[s].ls));
      cmp(1, "tbl_frame_start", int'(o1.fs), int'(tbl[s].fs));
    end
    nfs = 0;
    ticks = 0;
    repeat (5000) begin
      en = $urandom_range(0, 9) != 0;
      @(negedge clk);
      check_all();
      if (o1.fs) begin
        if (nfs > 0) cmp(1, "frame_ticks", ticks, SHT * SVT);
        nfs++;
        ticks = 0;
      end
      if (o1.tick) ticks++;
    end
    cmp(1, "frames_seen_ge2", int'(nfs >= 2), 1);
    en = 1'b1;
    for (int i = 0; i < 4000 && o0.h != 12'd700; i++) begin
      @(negedge clk);
      check_all();
    end
    cmp(0, "reach_h700", int'(o0.h), 700);
    #2 rst_n = 1'b0;
    #1 check_all();
    cmp(0, "async_h", int'(o0.h), 0);
    cmp(0, "async_hsync", int'(o0.hs), 1);
    cmp(2, "async_hsync", int'(o2.hs), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_all();
    end
    cmp(0, "restart_tick", int'(o0.tick), 1);
    cmp(0, "restart_h", int'(o0.h), 0);
    @(negedge clk);
    check_all();
    cmp(0, "restart_h_next", int'(o0.h), 1);
    cmp(0, "restart_v", int'(o0.v), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/video timing generator for the display path. It is the successor to the fixed-clock sync counter and adds:
- an internal pixel-clock-enable divider, so it runs from the 100 MHz board clock;
- programmable sync polarity;
- `en` gating;
- line and frame strobes;
- an optional sync/blank delay line that aligns sync with pipelined pixel renderers.

It sits between the system clock domain and the VGA pin drivers, and feeds coordinates to the renderer.

## Interface
- `H_RES`, 640: active pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48: horizontal front porch, sync, back porch (pixels)
- `V_RES`, 480: active lines per frame
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33: vertical front porch, sync, back porch (lines)
- `H_POL` / `V_POL`, 0 / 0: active level of hsync / vsync (0 = active-low)
- `PIX_DIV`, 4: `clk` cycles per pixel, ≥1
- `CNT_W`, 12: counter width; must hold `H_TOTAL-1` and `V_TOTAL-1`
- `PIPE_DEPTH`, 2: pixel ticks of sync/blank delay, ≥1; used only with `VGA_TIMING_PIPE_EN`
- `clk`  in  1  system clock; sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  run enable; low freezes all state
- `pix_tick`  out  1  one-`clk` pulse per pixel period
- `h_count`  out  `CNT_W`  current pixel column, 0..`H_TOTAL-1`
- `v_count`  out  `CNT_W`  current line, 0..`V_TOTAL-1`
- `hsync` / `vsync`  out  1  sync outputs at the configured polarity
- `video_on`  out  1  active-area flag
- `line_start`  out  1  one-`clk` pulse when `h_count` becomes 0
- `frame_start`  out  1  one-`clk` pulse when `h_count` and `v_count` both become 0

## Operation
- Totals:
  - `H_TOTAL = H_RES+H_FP+H_SYNC+H_BP` (default 800).
  - `V_TOTAL = V_RES+V_FP+V_SYNC+V_BP` (default 525).
- Divider:
  - `div_cnt` counts 0..`PIX_DIV-1` while `en` is high.
  - `pix_tick` is registered. It goes high for the one cycle after the edge where `div_cnt==PIX_DIV-1`.
  - With `PIX_DIV==1`, `pix_tick` stays high continuously while `en` is high.
- Counters advance only on edges where `pix_tick` is high:
  - `h_count` wraps `H_TOTAL-1`→0.
  - `v_count` increments only on an `h_count` wrap, and wraps `V_TOTAL-1`→0.
- Decode is computed from next-state counter values and registered, so `hsync`/`vsync`/`video_on` match `h_count`/`v_count` in the same cycle:
  - `hsync` is asserted for `H_RES+H_FP ≤ h < H_RES+H_FP+H_SYNC`.
  - `vsync` uses the same rule with the V parameters.
  - `video_on = (h<H_RES)&&(v<V_RES)`.
- Strobes:
  - `line_start` is high for exactly one `clk` cycle, immediately after the edge that loads `h_count=0`.
  - `frame_start` is the same when (0,0) is loaded. It coincides with a `line_start`.
- `en` low:
  - `div_cnt`, counters, sync and `video_on` hold their values; `pix_tick` and the strobes are 0.
  - When `en` returns high, counting resumes from the held state with no skipped or duplicated pixel.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - `div_cnt`, `h_count`, `v_count`: 0.
  - `pix_tick`, `line_start`, `frame_start`: 0.
  - `hsync`: `~H_POL`; `vsync`: `~V_POL`; `video_on`: 0.
  - All delay-line stages reset to their inactive values.
- Reset release:
  - No `frame_start` is emitted for the reset state (0,0).
  - The first `frame_start` occurs after one full frame.
- Period: `pix_tick` asserts every `PIX_DIV` cycles. Its first occurrence is `PIX_DIV` cycles after the first `en`-high edge following reset.
- Latency:
  - Counter to decode: 0 pixel ticks without the macro.
  - Counter to decode: `PIPE_DEPTH` pixel ticks with the macro.
- Frame boundaries:
  - At `h=H_TOTAL-1`, `v=V_TOTAL-1`, the next tick loads (0,0) and raises both strobes.
  - `video_on` rises in that same update.
- Reset mid-frame: all outputs return to reset values immediately. There is no partial strobe.

## Configuration
- `VGA_TIMING_PIPE_EN` defined:
  - `hsync`, `vsync` and `video_on` pass through a `PIPE_DEPTH`-stage shift register clocked by `pix_tick`, and lag `h_count`/`v_count` by `PIPE_DEPTH` pixel ticks.
  - Counters and strobes are not delayed.
- Undefined:
  - The delay line is absent; decode is aligned with the counters.
  - `PIPE_DEPTH` is ignored.

## Test plan
- Reset, default params, `en`=1, run 2 frames:
  - `pix_tick` is high every 4th cycle.
  - `h_count` wraps at 799 and `v_count` wraps at 524.
  - Exactly 420 000 `pix_tick`s occur between consecutive `frame_start`s.
- Sync windows, defaults:
  - `hsync`=0 exactly for `h_count` 656..751, otherwise 1.
  - `vsync`=0 for `v_count` 490..491.
  - `video_on`=1 only for h<640, v<480.
- `H_POL=1`, `V_POL=1`, `PIX_DIV=1`:
  - Sync is high inside the windows.
  - After reset, `hsync`=0 and `vsync`=0.
  - `pix_tick` is constant 1.
- Drop `en` for 37 cycles at h=100, v=5:
  - Counters hold at (100,5); no `pix_tick`.
  - On resume the next value is (101,5).
- Assert `rst_n`=0 at h=700, v=300:
  - All outputs return to reset values within the same cycle, asynchronously.
  - After release, counting restarts at (0,0).
- With `VGA_TIMING_PIPE_EN`, `PIPE_DEPTH=2`:
  - `hsync` falls 2 pixel ticks after `h_count` reaches 656.
  - `video_on` falls 2 ticks after `h_count`=640.
